// File: rtl/membridge_buf_pkg.sv
// Shared defaults and width helpers for the membridge data buffer and its FIFOs.
package membridge_buf_pkg;

    localparam int DATA_W_DEF     = 64;
    localparam int DEPTH_DEF      = 8;
    localparam int AFULL_MARGIN   = 2;

    // Level counters are one bit wider than the pointers so a full FIFO reads DEPTH.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int afull_th_def(input int depth);
        return depth - AFULL_MARGIN;
    endfunction

endpackage

// File: rtl/membridge_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with valid/ready ports,
// registered occupancy level and almost-full flag, plus a synchronous clear.
module membridge_sync_fifo
    import membridge_buf_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int AFULL_TH = afull_th_def(DEPTH)
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    afull
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = lvl_w(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [LVL_W-1:0]  level_reg;
    logic [LVL_W-1:0]  level_next;
    logic              afull_reg;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] storage [DEPTH];

    // A flush cycle refuses the push so no beat is acknowledged and then discarded.
    assign in_ready  = (level_reg != LVL_W'(DEPTH)) && !flush;
    assign out_valid = (level_reg != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_data  = out_valid ? storage[rd_ptr_reg] : '0;
    assign level     = level_reg;
    assign afull     = afull_reg;

    always_comb begin
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + LVL_W'(1);
            2'b01:   level_next = level_reg - LVL_W'(1);
            default: level_next = level_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            afull_reg  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            level_reg <= level_next;
            afull_reg <= (level_next >= LVL_W'(AFULL_TH));
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            storage[wr_ptr_reg] <= in_data;
        end
    end

endmodule

// File: rtl/membridge_data_buffer.sv
// Bidirectional membridge data buffer: host->memory write FIFO and memory->host read FIFO.
// Define MEMBRIDGE_BUF_FLUSH_EN to add a flush port that empties both FIFOs like sys_rst.
module membridge_data_buffer
    import membridge_buf_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int AFULL_TH = afull_th_def(DEPTH)
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
`ifdef MEMBRIDGE_BUF_FLUSH_EN
    input  logic                    flush,
`endif
    input  logic                    host_wr_valid,
    output logic                    host_wr_ready,
    input  logic [DATA_W-1:0]       host_wr_data,
    output logic                    mem_wr_valid,
    input  logic                    mem_wr_ready,
    output logic [DATA_W-1:0]       mem_wr_data,
    input  logic                    mem_rd_valid,
    output logic                    mem_rd_ready,
    input  logic [DATA_W-1:0]       mem_rd_data,
    output logic                    host_rd_valid,
    input  logic                    host_rd_ready,
    output logic [DATA_W-1:0]       host_rd_data,
    output logic [$clog2(DEPTH):0]  wr_level,
    output logic [$clog2(DEPTH):0]  rd_level,
    output logic                    wr_afull,
    output logic                    rd_afull
);

    logic clear_req;

`ifdef MEMBRIDGE_BUF_FLUSH_EN
    assign clear_req = flush;
`else
    assign clear_req = 1'b0;
`endif

    membridge_sync_fifo #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL_TH)
    ) u_wr_fifo (
        .clk       (sys_clk),
        .srst      (sys_rst),
        .flush     (clear_req),
        .in_valid  (host_wr_valid),
        .in_ready  (host_wr_ready),
        .in_data   (host_wr_data),
        .out_valid (mem_wr_valid),
        .out_ready (mem_wr_ready),
        .out_data  (mem_wr_data),
        .level     (wr_level),
        .afull     (wr_afull)
    );

    membridge_sync_fifo #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL_TH)
    ) u_rd_fifo (
        .clk       (sys_clk),
        .srst      (sys_rst),
        .flush     (clear_req),
        .in_valid  (mem_rd_valid),
        .in_ready  (mem_rd_ready),
        .in_data   (mem_rd_data),
        .out_valid (host_rd_valid),
        .out_ready (host_rd_ready),
        .out_data  (host_rd_data),
        .level     (rd_level),
        .afull     (rd_afull)
    );

endmodule

// File: tb/tb_membridge_data_buffer.sv
// Scoreboard bench for membridge_data_buffer: per-path queue models checked every cycle.
module tb_membridge_data_buffer;

    localparam int DATA_W   = 64;
    localparam int DEPTH    = 8;
    localparam int AFULL_TH = 6;
    localparam int LVL_W    = $clog2(DEPTH) + 1;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic              flush_v = 1'b0;
    logic              host_wr_valid;
    logic              host_wr_ready;
    logic [DATA_W-1:0] host_wr_data;
    logic              mem_wr_valid;
    logic              mem_wr_ready;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_rd_valid;
    logic              mem_rd_ready;
    logic [DATA_W-1:0] mem_rd_data;
    logic              host_rd_valid;
    logic              host_rd_ready;
    logic [DATA_W-1:0] host_rd_data;
    logic [LVL_W-1:0]  wr_level;
    logic [LVL_W-1:0]  rd_level;
    logic              wr_afull;
    logic              rd_afull;

    int  checks = 0;
    int  errors = 0;
    bit  armed  = 1'b0;

    logic [DATA_W-1:0] wr_model [$];
    logic [DATA_W-1:0] rd_model [$];

    always #5 sys_clk = ~sys_clk;

    membridge_data_buffer #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL_TH)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
`ifdef MEMBRIDGE_BUF_FLUSH_EN
        .flush         (flush_v),
`endif
        .host_wr_valid (host_wr_valid),
        .host_wr_ready (host_wr_ready),
        .host_wr_data  (host_wr_data),
        .mem_wr_valid  (mem_wr_valid),
        .mem_wr_ready  (mem_wr_ready),
        .mem_wr_data   (mem_wr_data),
        .mem_rd_valid  (mem_rd_valid),
        .mem_rd_ready  (mem_rd_ready),
        .mem_rd_data   (mem_rd_data),
        .host_rd_valid (host_rd_valid),
        .host_rd_ready (host_rd_ready),
        .host_rd_data  (host_rd_data),
        .wr_level      (wr_level),
        .rd_level      (rd_level),
        .wr_afull      (wr_afull),
        .rd_afull      (rd_afull)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Write path monitor: compare outputs against the queue model, then apply this edge's transfers.
    logic wr_do_push, wr_do_pop;
    always @(negedge sys_clk) begin
        if (armed) begin
            check("wr_in_ready", 64'(host_wr_ready), 64'((wr_model.size() != DEPTH) && !flush_v));
            check("wr_out_valid", 64'(mem_wr_valid), 64'(wr_model.size() != 0));
            check("wr_out_data", mem_wr_data, (wr_model.size() != 0) ? wr_model[0] : 64'd0);
            check("wr_level", 64'(wr_level), 64'(wr_model.size()));
            check("wr_afull", 64'(wr_afull), 64'(wr_model.size() >= AFULL_TH));
            if (host_wr_valid && host_wr_ready)
                $display("wr push %h level=%0d", host_wr_data, wr_model.size());
            if (mem_wr_valid && mem_wr_ready)
                $display("wr pop  %h level=%0d", mem_wr_data, wr_model.size());
        end
        if (sys_rst || flush_v) begin
            wr_model.delete();
        end else begin
            wr_do_push = host_wr_valid && (wr_model.size() != DEPTH);
            wr_do_pop  = mem_wr_ready && (wr_model.size() != 0);
            if (wr_do_pop)  void'(wr_model.pop_front());
            if (wr_do_push) wr_model.push_back(host_wr_data);
        end
    end

    logic rd_do_push, rd_do_pop;
    always @(negedge sys_clk) begin
        if (armed) begin
            check("rd_in_ready", 64'(mem_rd_ready), 64'((rd_model.size() != DEPTH) && !flush_v));
            check("rd_out_valid", 64'(host_rd_valid), 64'(rd_model.size() != 0));
            check("rd_out_data", host_rd_data, (rd_model.size() != 0) ? rd_model[0] : 64'd0);
            check("rd_level", 64'(rd_level), 64'(rd_model.size()));
            check("rd_afull", 64'(rd_afull), 64'(rd_model.size() >= AFULL_TH));
            if (mem_rd_valid && mem_rd_ready)
                $display("rd push %h level=%0d", mem_rd_data, rd_model.size());
            if (host_rd_valid && host_rd_ready)
                $display("rd pop  %h level=%0d", host_rd_data, rd_model.size());
        end
        if (sys_rst || flush_v) begin
            rd_model.delete();
        end else begin
            rd_do_push = mem_rd_valid && (rd_model.size() != DEPTH);
            rd_do_pop  = host_rd_ready && (rd_model.size() != 0);
            if (rd_do_pop)  void'(rd_model.pop_front());
            if (rd_do_push) rd_model.push_back(mem_rd_data);
        end
    end

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        sys_rst       = 1'b1;
        host_wr_valid = 1'b0;
        host_wr_data  = '0;
        mem_wr_ready  = 1'b0;
        mem_rd_valid  = 1'b0;
        mem_rd_data   = '0;
        host_rd_ready = 1'b0;
        step();
        step();
        sys_rst = 1'b0;
        armed   = 1'b1;

        // Fill the write FIFO with 0x11..0x88, then offer one more beat into the full FIFO.
        for (int k = 1; k <= 8; k++) begin
            host_wr_valid = 1'b1;
            host_wr_data  = 64'(k * 17);
            step();
        end
        host_wr_data = 64'h99;
        step();

        // Drain in order and continue one cycle past empty.
        host_wr_valid = 1'b0;
        mem_wr_ready  = 1'b1;
        repeat (9) step();

        // Hold level 4 with simultaneous push/pop across pointer wrap.
        mem_wr_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            host_wr_valid = 1'b1;
            host_wr_data  = rand64();
            step();
        end
        mem_wr_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            host_wr_data = rand64();
            step();
        end
        host_wr_valid = 1'b0;
        repeat (5) step();

        // Full FIFO with pop and push offered together.
        mem_wr_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            host_wr_valid = 1'b1;
            host_wr_data  = rand64();
            step();
        end
        host_wr_data = rand64();
        mem_wr_ready = 1'b1;
        step();
        host_wr_valid = 1'b0;
        mem_wr_ready  = 1'b0;
        step();
        mem_wr_ready = 1'b1;
        repeat (9) step();

        // Random concurrent traffic on both paths.
        for (int k = 0; k < 400; k++) begin
            host_wr_valid = 1'($urandom_range(0, 1));
            host_wr_data  = rand64();
            mem_wr_ready  = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
            mem_rd_valid  = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            mem_rd_data   = rand64();
            host_rd_ready = 1'($urandom_range(0, 1));
            step();
        end

        // Drain, build level 5 on both paths, then reset with pushes offered.
        host_wr_valid = 1'b0;
        mem_rd_valid  = 1'b0;
        mem_wr_ready  = 1'b1;
        host_rd_ready = 1'b1;
        repeat (10) step();
        mem_wr_ready  = 1'b0;
        host_rd_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            host_wr_valid = 1'b1;
            host_wr_data  = rand64();
            mem_rd_valid  = 1'b1;
            mem_rd_data   = rand64();
            step();
        end
        sys_rst      = 1'b1;
        host_wr_data = rand64();
        mem_rd_data  = rand64();
        step();
        sys_rst       = 1'b0;
        host_wr_valid = 1'b0;
        mem_rd_valid  = 1'b0;
        step();
        step();

`ifdef MEMBRIDGE_BUF_FLUSH_EN
        for (int k = 0; k < 5; k++) begin
            host_wr_valid = 1'b1;
            host_wr_data  = rand64();
            mem_rd_valid  = 1'b1;
            mem_rd_data   = rand64();
            step();
        end
        flush_v      = 1'b1;
        host_wr_data = rand64();
        mem_rd_data  = rand64();
        step();
        flush_v       = 1'b0;
        host_wr_valid = 1'b0;
        mem_rd_valid  = 1'b0;
        step();
        step();
`endif

        // Short refill after the clear to confirm both paths resume.
        for (int k = 0; k < 12; k++) begin
            host_wr_valid = 1'($urandom_range(0, 1));
            host_wr_data  = rand64();
            mem_wr_ready  = 1'($urandom_range(0, 1));
            mem_rd_valid  = 1'($urandom_range(0, 1));
            mem_rd_data   = rand64();
            host_rd_ready = 1'($urandom_range(0, 1));
            step();
        end

        @(negedge sys_clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
